// File: rtl/pixel_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_seq_pkg
// Purpose  : Shared types and constants for the pixel frame sequencer:
//            the frame state enumeration, the read-group select codes and
//            helpers for computing phase-counter reload values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pixel_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ0   = 3'd4,
    ST_READ1   = 3'd5
  } state_e;

  localparam logic [3:0] READ_GRP0 = 4'b0011;
  localparam logic [3:0] READ_GRP1 = 4'b1100;
  localparam logic [3:0] READ_NONE = 4'b0000;

  // The phase counter runs len-1 .. 0, so a phase of len cycles
  // is loaded with len-1 on entry.
  function automatic logic [7:0] phase_reload(input logic [7:0] len);
    return len - 8'd1;
  endfunction

  // A zero exposure request selects the default exposure length.
  function automatic logic [7:0] expose_length(input logic [7:0] cfg,
                                               input logic [7:0] dflt);
    return (cfg == 8'd0) ? dflt : cfg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pix_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : pix_out_reg
// Purpose  : One-entry output register with a valid/ready handshake.
//            A load may coincide with a downstream transfer; the new word
//            replaces the old one and valid stays high.
// Ports    : clk_i         clock, rising edge
//            reset_i       asynchronous active-high reset (drops the word)
//            load_i        load load_data_i (only when can_load_o is high)
//            load_data_i   word to load
//            can_load_o    register is empty or is being drained this cycle
//            out_data_o    held word
//            out_valid_o   out_data_o holds a word
//            out_ready_i   downstream accepts the word
// Revision : 1.0 - initial release
// ============================================================================
module pix_out_reg (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [15:0] load_data_i,
  output logic        can_load_o,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  logic [15:0] data_q;
  logic        valid_q;

  assign can_load_o  = ~valid_q | out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q  <= 16'd0;
      valid_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q  <= load_data_i;
        valid_q <= 1'b1;
      end else if (out_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_sequencer
// Purpose  : Frame-level controller for the pixel array. Sequences
//            ERASE -> EXPOSE -> CONVERT -> READ0 -> READ1, generates the ADC
//            ramp during CONVERT and captures one pixel word per read group
//            into a valid/ready output register.
// Ports    : clk_i          clock, rising edge
//            reset_i        asynchronous active-high reset
//            start_i        frame request, honoured only in IDLE
//            cfg_expose_i   exposure length, latched on start (0 => default)
//            erase_o        pixel erase
//            expose_o       pixel expose
//            convert_o      ADC ramp active
//            read_o         read-group select code
//            adc_ramp_o     digital ramp value (0 outside CONVERT)
//            pix_data_i     pixel bus value while read_o != 0
//            out_data_o     captured pixel word
//            out_valid_o    out_data_o holds a word
//            out_ready_i    downstream accepts the word
//            busy_o         a frame is in progress
//            frame_done_o   one-cycle pulse after the group-1 capture
// Revision : 1.0 - initial release
// ============================================================================
module pixel_frame_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int unsigned C_ERASE   = 5,
  parameter int unsigned C_EXPOSE  = 255,
  parameter int unsigned C_CONVERT = 255,
  parameter int unsigned C_READ    = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  cfg_expose_i,
  output logic        erase_o,
  output logic        expose_o,
  output logic        convert_o,
  output logic [3:0]  read_o,
  output logic [7:0]  adc_ramp_o,
  input  logic [15:0] pix_data_i,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam logic [7:0] ERASE_LEN   = 8'(C_ERASE);
  localparam logic [7:0] EXPOSE_DFLT = 8'(C_EXPOSE);
  localparam logic [7:0] CONVERT_LEN = 8'(C_CONVERT);
  localparam logic [7:0] READ_LEN    = 8'(C_READ);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  expose_len_q;
  logic        erase_q;
  logic        expose_q;
  logic        convert_q;
  logic [3:0]  read_q;
  logic [7:0]  ramp_q;
  logic        busy_q;
  logic        frame_done_q;

  logic        can_load;
  logic        capture;

  // A read window captures on its last cycle, but only once the output
  // register can take the word; until then the FSM stalls on that cycle.
  assign capture = (cnt_q == 8'd0) && can_load &&
                   ((state_q == ST_READ0) || (state_q == ST_READ1));

  pix_out_reg u_out_reg (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (capture),
    .load_data_i (pix_data_i),
    .can_load_o  (can_load),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      expose_len_q <= 8'd0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      read_q       <= READ_NONE;
      ramp_q       <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q      <= ST_ERASE;
            cnt_q        <= phase_reload(ERASE_LEN);
            expose_len_q <= expose_length(cfg_expose_i, EXPOSE_DFLT);
            erase_q      <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_ERASE: begin
          if (cnt_q == 8'd0) begin
            state_q  <= ST_EXPOSE;
            cnt_q    <= phase_reload(expose_len_q);
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_EXPOSE: begin
          if (cnt_q == 8'd0) begin
            state_q   <= ST_CONVERT;
            cnt_q     <= phase_reload(CONVERT_LEN);
            expose_q  <= 1'b0;
            convert_q <= 1'b1;
            ramp_q    <= 8'd0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_CONVERT: begin
          if (cnt_q == 8'd0) begin
            state_q   <= ST_READ0;
            cnt_q     <= phase_reload(READ_LEN);
            convert_q <= 1'b0;
            ramp_q    <= 8'd0;
            read_q    <= READ_GRP0;
          end else begin
            cnt_q  <= cnt_q - 8'd1;
            ramp_q <= ramp_q + 8'd1;
          end
        end
        ST_READ0: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (can_load) begin
            state_q <= ST_READ1;
            cnt_q   <= phase_reload(READ_LEN);
            read_q  <= READ_GRP1;
          end
        end
        ST_READ1: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (can_load) begin
            state_q      <= ST_IDLE;
            read_q       <= READ_NONE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign erase_o      = erase_q;
  assign expose_o     = expose_q;
  assign convert_o    = convert_q;
  assign read_o       = read_q;
  assign adc_ramp_o   = ramp_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_frame_sequencer
// Purpose  : Self-checking bench for pixel_frame_sequencer. A frame-timeline
//            reference model predicts phase outputs, ramp values, captures
//            and the output-register contents every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_sequencer;

  localparam int T_ERASE   = 5;
  localparam int T_EXPOSE  = 255;
  localparam int T_CONVERT = 255;
  localparam int T_READ    = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start;
  logic [7:0]  cfg_expose;
  logic [15:0] pix_data;
  logic        out_ready;
  logic        erase, expose, convert, out_valid, busy, frame_done;
  logic [3:0]  read;
  logic [7:0]  adc_ramp;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  pixel_frame_sequencer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .cfg_expose_i (cfg_expose),
    .erase_o      (erase),
    .expose_o     (expose),
    .convert_o    (convert),
    .read_o       (read),
    .adc_ramp_o   (adc_ramp),
    .pix_data_i   (pix_data),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame timeline measured in cycles since the first
  // busy cycle; read windows stretch by one cycle per stalled sample.
  logic [15:0] sb[$];
  bit          m_busy = 1'b0;
  bit          m_fd   = 1'b0;
  int          m_t, m_n, m_r0_end, m_r1_end;
  logic [15:0] pd0, pd1;
  int          ready_mode;
  int          accepts = 0, fd_seen = 0, aborted = 0;
  int          run_erase, run_expose, run_convert, run_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_erase"}, erase, 0);
    chk({tag, "_expose"}, expose, 0);
    chk({tag, "_convert"}, convert, 0);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_ramp"}, adc_ramp, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
  endtask

  // Called at a falling edge: drives inputs for the next rising edge,
  // checks the current cycle against the model, advances the model.
  task automatic step(input logic st);
    int       ph;
    int       ramp_e;
    bit       can;
    ph = 0;
    ramp_e = 0;
    if (m_busy) begin
      if (m_t < T_ERASE) ph = 1;
      else if (m_t < T_ERASE + m_n) ph = 2;
      else if (m_t < T_ERASE + m_n + T_CONVERT) begin
        ph = 3;
        ramp_e = m_t - T_ERASE - m_n;
      end
      else if (m_t < m_r0_end) ph = 4;
      else ph = 5;
    end
    pix_data  = (ph == 4) ? pd0 : (ph == 5) ? pd1 : 16'($urandom);
    out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom) : 1'b0;
    start     = st;

    chk("erase", erase, (ph == 1));
    chk("expose", expose, (ph == 2));
    chk("convert", convert, (ph == 3));
    chk("read", read, (ph == 4) ? 4'b0011 : (ph == 5) ? 4'b1100 : 4'b0000);
    chk("adc_ramp", adc_ramp, 32'(ramp_e));
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_fd);
    chk("out_valid", out_valid, (sb.size() != 0));
    if (sb.size() != 0) chk("out_data", out_data, sb[0]);
    chk("phase_onehot", ($countones({erase, expose, convert, (read != 4'd0)}) <= 1), 1);

    run_erase   += int'(erase);
    run_expose  += int'(expose);
    run_convert += int'(convert);
    run_valid   += int'(out_valid);
    fd_seen     += int'(frame_done);

    can  = (sb.size() == 0) || out_ready;
    if ((sb.size() != 0) && out_ready) void'(sb.pop_front());
    m_fd = 1'b0;
    if (m_busy) begin
      if (ph == 4 && m_t == m_r0_end - 1) begin
        if (can) sb.push_back(pd0);
        else begin
          m_r0_end++;
          m_r1_end++;
        end
      end
      if (ph == 5 && m_t == m_r1_end - 1) begin
        if (can) begin
          sb.push_back(pd1);
          m_busy = 1'b0;
          m_fd   = 1'b1;
        end else m_r1_end++;
      end
      m_t++;
    end else if (st) begin
      m_busy   = 1'b1;
      m_t      = 0;
      m_n      = (cfg_expose == 8'd0) ? T_EXPOSE : int'(cfg_expose);
      m_r0_end = T_ERASE + m_n + T_CONVERT + T_READ;
      m_r1_end = m_r0_end + T_READ;
      accepts++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cfg, input int mode, input bit noise);
    cfg_expose = cfg;
    ready_mode = mode;
    run_erase = 0; run_expose = 0; run_convert = 0; run_valid = 0;
    step(1'b1);
    cfg_expose = 8'($urandom);
    for (int i = 0; i < 3000 && (m_busy || m_fd); i++)
      step((noise && m_busy) ? 1'($urandom) : 1'b0);
    chk("frame_timeout", (m_busy || m_fd), 0);
  endtask

  initial begin
    start = 1'b0; cfg_expose = 8'd0; pix_data = 16'd0; out_ready = 1'b1;
    ready_mode = 0; pd0 = 16'hA5A5; pd1 = 16'h3C3C;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Default-length frame with a free-flowing output.
    run_frame(8'd0, 0, 1'b0);
    chk("len_erase", run_erase, T_ERASE);
    chk("len_expose_dflt", run_expose, T_EXPOSE);
    chk("len_convert", run_convert, T_CONVERT);
    chk("valid_cycles", run_valid, 2);

    run_frame(8'd10, 0, 1'b0);
    chk("len_expose_10", run_expose, 10);
    run_frame(8'd0, 0, 1'b0);
    chk("len_expose_dflt2", run_expose, T_EXPOSE);

    // Backpressure: downstream never ready, FSM stalls in READ1.
    cfg_expose = 8'd3;
    ready_mode = 2;
    step(1'b1);
    repeat (T_ERASE + 3 + T_CONVERT + 2 * T_READ + 4) step(1'b0);
    chk("stall_read", read, 4'b1100);
    chk("stall_data", out_data, 16'hA5A5);
    chk("stall_valid", out_valid, 1);
    chk("stall_busy", busy, 1);
    ready_mode = 0;
    step(1'b0);
    ready_mode = 2;
    chk("swap_valid", out_valid, 1);
    chk("swap_data", out_data, 16'h3C3C);
    step(1'b0);
    ready_mode = 0;
    repeat (2) step(1'b0);

    // Reset in the middle of CONVERT.
    cfg_expose = 8'd0;
    ready_mode = 0;
    step(1'b1);
    for (int i = 0; i < 1000 && m_t != T_ERASE + T_EXPOSE + 100; i++)
      step(1'($urandom));
    chk("ramp_before_reset", adc_ramp, 100);
    start = 1'b0;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    m_busy = 1'b0; m_fd = 1'b0; sb.delete(); aborted++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("post_reset");
    repeat (3) step(1'b0);

    // Random frames with random backpressure and stray start pulses.
    for (int f = 0; f < 110; f++) begin
      pd0 = 16'($urandom);
      pd1 = 16'($urandom);
      run_frame(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 30)), 1, 1'b1);
    end

    ready_mode = 0;
    repeat (3) step(1'b0);
    chk("drained_valid", out_valid, 0);
    chk("done_per_start", fd_seen, accepts - aborted);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
